// File: rtl/pipe_stage_reg_pkg.sv
// Shared encodings for the elastic pipeline stage register.
// Occupancy codes, NOP default and stall counter helpers.
package pipe_stage_reg_pkg;

   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   localparam int STALL_W = 16;
   localparam logic [STALL_W-1:0] STALL_MAX = '1;

   function automatic logic [STALL_W-1:0] stall_next(
      input logic [STALL_W-1:0] cnt,
      input logic               inc
   );
      if (inc && (cnt != STALL_MAX))
         return cnt + 1'b1;
      return cnt;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One entry of a pipeline stage: valid + instruction + payload.
// Clear wins over load so a flush always leaves a true NOP.
module pipe_slot #(
   parameter int                 INSTR_W = 32,
   parameter int                 DATA_W  = 96,
   parameter logic [INSTR_W-1:0] NOP     = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_load,
   input  logic               i_clear,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [DATA_W-1:0]  i_data,
   output logic               o_valid,
   output logic [INSTR_W-1:0] o_instr,
   output logic [DATA_W-1:0]  o_data
);

   logic               r_valid;
   logic [INSTR_W-1:0] r_instr;
   logic [DATA_W-1:0]  r_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_instr <= NOP;
         r_data  <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_instr <= NOP;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with optional skid slot,
// synchronous flush to NOP and a saturating stall counter.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int                 INSTR_W = 32,
   parameter int                 DATA_W  = 96,
   parameter logic [INSTR_W-1:0] NOP     = NOP_DEFAULT,
   parameter bit                 SKID    = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [DATA_W-1:0]  out_data,
   output logic [1:0]         occupancy,
   output logic [STALL_W-1:0] stall_cnt
);

   logic               w_in_fire;
   logic               w_out_fire;
   logic               w_stall;
   logic               w_main_v;
   logic [INSTR_W-1:0] w_main_i;
   logic [DATA_W-1:0]  w_main_d;
   logic               w_main_ld;
   logic               w_main_clr;
   logic [INSTR_W-1:0] w_main_src_i;
   logic [DATA_W-1:0]  w_main_src_d;
   logic [STALL_W-1:0] r_stall;

   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = w_main_v && out_ready;
   assign w_stall    = in_valid && !in_ready;

   pipe_slot #(
      .INSTR_W (INSTR_W),
      .DATA_W  (DATA_W),
      .NOP     (NOP)
   ) u_main (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_main_ld),
      .i_clear (w_main_clr),
      .i_instr (w_main_src_i),
      .i_data  (w_main_src_d),
      .o_valid (w_main_v),
      .o_instr (w_main_i),
      .o_data  (w_main_d)
   );

   generate
      if (SKID) begin : g_skid
         logic               w_skid_v;
         logic [INSTR_W-1:0] w_skid_i;
         logic [DATA_W-1:0]  w_skid_d;
         logic               w_skid_ld;
         logic               w_skid_clr;
         logic [1:0]         w_occ;
         logic [1:0]         w_occ_nx;
         logic               r_in_ready;

         pipe_slot #(
            .INSTR_W (INSTR_W),
            .DATA_W  (DATA_W),
            .NOP     (NOP)
         ) u_skid (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_skid_ld),
            .i_clear (w_skid_clr),
            .i_instr (in_instr),
            .i_data  (in_data),
            .o_valid (w_skid_v),
            .o_instr (w_skid_i),
            .o_data  (w_skid_d)
         );

         assign w_occ = {1'b0, w_main_v} + {1'b0, w_skid_v};

         always_comb begin
            w_occ_nx     = w_occ;
            w_main_ld    = 1'b0;
            w_main_clr   = 1'b0;
            w_skid_ld    = 1'b0;
            w_skid_clr   = 1'b0;
            w_main_src_i = in_instr;
            w_main_src_d = in_data;
            if (flush) begin
               w_occ_nx   = OCC_EMPTY;
               w_main_clr = 1'b1;
               w_skid_clr = 1'b1;
            end else begin
               unique case (w_occ)
                  OCC_EMPTY: begin
                     if (w_in_fire) begin
                        w_occ_nx  = OCC_ONE;
                        w_main_ld = 1'b1;
                     end
                  end
                  OCC_ONE: begin
                     if (w_in_fire && w_out_fire) begin
                        w_main_ld = 1'b1;
                     end else if (w_in_fire) begin
                        w_occ_nx  = OCC_FULL;
                        w_skid_ld = 1'b1;
                     end else if (w_out_fire) begin
                        w_occ_nx   = OCC_EMPTY;
                        w_main_clr = 1'b1;
                     end
                  end
                  OCC_FULL: begin
                     // skid drains into main; never overtakes it
                     if (w_out_fire) begin
                        w_occ_nx     = OCC_ONE;
                        w_main_ld    = 1'b1;
                        w_main_src_i = w_skid_i;
                        w_main_src_d = w_skid_d;
                        w_skid_clr   = 1'b1;
                     end
                  end
                  default: begin
                     w_occ_nx   = OCC_EMPTY;
                     w_main_clr = 1'b1;
                     w_skid_clr = 1'b1;
                  end
               endcase
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               r_in_ready <= 1'b1;
            else
               r_in_ready <= (w_occ_nx != OCC_FULL);
         end

         assign in_ready  = r_in_ready;
         assign occupancy = w_occ;
      end else begin : g_single
         assign in_ready     = !w_main_v || out_ready;
         assign occupancy    = {1'b0, w_main_v};
         assign w_main_ld    = w_in_fire;
         assign w_main_clr   = flush || (w_out_fire && !w_in_fire);
         assign w_main_src_i = in_instr;
         assign w_main_src_d = in_data;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall <= '0;
      else
         r_stall <= stall_next(r_stall, w_stall);
   end

   assign out_valid = w_main_v;
   assign out_instr = w_main_i;
   assign out_data  = w_main_d;
   assign stall_cnt = r_stall;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg, skid and single-slot builds.
// Entries are queued on acceptance and compared on delivery.
module tb_pipe_stage_reg;
   import pipe_stage_reg_pkg::*;

   localparam int IW = 32;
   localparam int DW = 96;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic          s1_flush, s1_iv, s1_ir, s1_ov, s1_or;
   logic [IW-1:0] s1_ii, s1_oi;
   logic [DW-1:0] s1_id, s1_od;
   logic [1:0]    s1_occ;
   logic [15:0]   s1_st;

   logic          s0_flush, s0_iv, s0_ir, s0_ov, s0_or;
   logic [IW-1:0] s0_ii, s0_oi;
   logic [DW-1:0] s0_id, s0_od;
   logic [1:0]    s0_occ;
   logic [15:0]   s0_st;

   int checks   = 0;
   int failures = 0;
   int exp_stall = 0;

   typedef struct packed {
      logic [IW-1:0] i;
      logic [DW-1:0] d;
   } ent_t;

   ent_t q1[$];
   ent_t q0[$];

   function automatic logic [DW-1:0] mkd(input logic [IW-1:0] i);
      return {i, ~i, i ^ 32'h5A5A_5A5A};
   endfunction

   pipe_stage_reg #(.SKID(1'b1)) u_s1 (
      .clk(clk), .reset(reset), .flush(s1_flush),
      .in_valid(s1_iv), .in_ready(s1_ir),
      .in_instr(s1_ii), .in_data(s1_id),
      .out_valid(s1_ov), .out_ready(s1_or),
      .out_instr(s1_oi), .out_data(s1_od),
      .occupancy(s1_occ), .stall_cnt(s1_st)
   );

   pipe_stage_reg #(.SKID(1'b0)) u_s0 (
      .clk(clk), .reset(reset), .flush(s0_flush),
      .in_valid(s0_iv), .in_ready(s0_ir),
      .in_instr(s0_ii), .in_data(s0_id),
      .out_valid(s0_ov), .out_ready(s0_or),
      .out_instr(s0_oi), .out_data(s0_od),
      .occupancy(s0_occ), .stall_cnt(s0_st)
   );

   always @(negedge clk) begin
      ent_t e;
      if (!reset || s1_flush) begin
         q1.delete();
      end else begin
         if (s1_ov && s1_or) begin
            checks++;
            if (q1.size() == 0) begin
               failures++;
               $display("FAIL sb1_underflow got=%h required=queued", s1_oi);
            end else begin
               e = q1.pop_front();
               if (s1_oi !== e.i || s1_od !== e.d) begin
                  failures++;
                  $display("FAIL sb1_order got=%h/%h required=%h/%h",
                           s1_oi, s1_od, e.i, e.d);
               end
            end
         end
         if (s1_iv && s1_ir) q1.push_back({s1_ii, mkd(s1_ii)});
      end
   end

   always @(negedge clk) begin
      ent_t e;
      if (!reset || s0_flush) begin
         q0.delete();
      end else begin
         if (s0_ov && s0_or) begin
            checks++;
            if (q0.size() == 0) begin
               failures++;
               $display("FAIL sb0_underflow got=%h required=queued", s0_oi);
            end else begin
               e = q0.pop_front();
               if (s0_oi !== e.i || s0_od !== e.d) begin
                  failures++;
                  $display("FAIL sb0_order got=%h/%h required=%h/%h",
                           s0_oi, s0_od, e.i, e.d);
               end
            end
         end
         if (s0_iv && s0_ir) q0.push_back({s0_ii, mkd(s0_ii)});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set1(input logic v, input logic [IW-1:0] i);
      s1_iv = v;
      s1_ii = i;
      s1_id = mkd(i);
   endtask

   task automatic set0(input logic v, input logic [IW-1:0] i);
      s0_iv = v;
      s0_ii = i;
      s0_id = mkd(i);
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if (s1_occ !== 2'd0 || s1_ov !== 1'b0 || s1_ir !== 1'b1) begin
         failures++;
         $display("FAIL reset_s1_ctl got=occ%0d v%b r%b required=occ0 v0 r1",
                  s1_occ, s1_ov, s1_ir);
      end
      checks++;
      if (s1_oi !== 32'h0 || s1_od !== '0 || s1_st !== 16'h0) begin
         failures++;
         $display("FAIL reset_s1_data got=%h/%h/%h required=0/0/0",
                  s1_oi, s1_od, s1_st);
      end
      checks++;
      if (s0_occ !== 2'd0 || s0_ov !== 1'b0 || s0_ir !== 1'b1) begin
         failures++;
         $display("FAIL reset_s0_ctl got=occ%0d v%b r%b required=occ0 v0 r1",
                  s0_occ, s0_ov, s0_ir);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_streaming();
      logic [IW-1:0] v;
      s1_or = 1'b1;
      for (int k = 0; k < 8; k++) begin
         v = 32'h2401_0001 + k;
         set1(1'b1, v);
         tick();
         checks++;
         if (s1_occ !== 2'd1 || s1_oi !== v || s1_ir !== 1'b1) begin
            failures++;
            $display("FAIL stream_%0d got=occ%0d %h r%b required=occ1 %h r1",
                     k, s1_occ, s1_oi, s1_ir, v);
         end
      end
      set1(1'b0, '0);
      tick();
      checks++;
      if (s1_occ !== 2'd0 || s1_ov !== 1'b0 || s1_oi !== 32'h0) begin
         failures++;
         $display("FAIL stream_drain got=occ%0d v%b %h required=occ0 v0 0",
                  s1_occ, s1_ov, s1_oi);
      end
      checks++;
      if (s1_st !== 16'(exp_stall)) begin
         failures++;
         $display("FAIL stream_stall got=%0d required=%0d", s1_st, exp_stall);
      end
   endtask

   task automatic test_backpressure();
      logic [IW-1:0] bp [3];
      logic acc;
      int idx;
      bp[0] = 32'h2402_00A0;
      bp[1] = 32'h2402_00A1;
      bp[2] = 32'h2402_00A2;
      idx = 0;
      s1_or = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         set1(1'b1, bp[idx]);
         acc = s1_ir;
         tick();
         if (acc) idx++;
         checks++;
         if (s1_occ !== ((c == 1) ? 2'd1 : 2'd2) ||
             s1_ir !== ((c == 1) ? 1'b1 : 1'b0)) begin
            failures++;
            $display("FAIL bp_cycle%0d got=occ%0d r%b required=occ%0d r%b",
                     c, s1_occ, s1_ir, (c == 1) ? 1 : 2, c == 1);
         end
      end
      exp_stall += 2;
      checks++;
      if (s1_st !== 16'(exp_stall) || s1_oi !== bp[0]) begin
         failures++;
         $display("FAIL bp_hold got=st%0d %h required=st%0d %h",
                  s1_st, s1_oi, exp_stall, bp[0]);
      end
      s1_or = 1'b1;
      tick();
      exp_stall += 1;
      checks++;
      if (s1_occ !== 2'd1 || s1_oi !== bp[1] || s1_ir !== 1'b1) begin
         failures++;
         $display("FAIL bp_release got=occ%0d %h r%b required=occ1 %h r1",
                  s1_occ, s1_oi, s1_ir, bp[1]);
      end
      tick();
      checks++;
      if (s1_occ !== 2'd1 || s1_oi !== bp[2]) begin
         failures++;
         $display("FAIL bp_resume got=occ%0d %h required=occ1 %h",
                  s1_occ, s1_oi, bp[2]);
      end
      set1(1'b0, '0);
      tick();
      checks++;
      if (s1_occ !== 2'd0 || s1_st !== 16'(exp_stall)) begin
         failures++;
         $display("FAIL bp_end got=occ%0d st%0d required=occ0 st%0d",
                  s1_occ, s1_st, exp_stall);
      end
   endtask

   task automatic test_flush();
      s1_or = 1'b0;
      set1(1'b1, 32'h2403_00F0);
      tick();
      set1(1'b1, 32'h2403_00F1);
      tick();
      set1(1'b0, '0);
      s1_flush = 1'b1;
      tick();
      s1_flush = 1'b0;
      checks++;
      if (s1_occ !== 2'd0 || s1_ov !== 1'b0 || s1_ir !== 1'b1) begin
         failures++;
         $display("FAIL flush_full got=occ%0d v%b r%b required=occ0 v0 r1",
                  s1_occ, s1_ov, s1_ir);
      end
      checks++;
      if (s1_oi !== 32'h0 || s1_od !== '0 || s1_st !== 16'(exp_stall)) begin
         failures++;
         $display("FAIL flush_nop got=%h/%h st%0d required=0/0 st%0d",
                  s1_oi, s1_od, s1_st, exp_stall);
      end
      set1(1'b1, 32'h2403_00F2);
      tick();
      set1(1'b1, 32'h2403_00F3);
      s1_flush = 1'b1;
      tick();
      s1_flush = 1'b0;
      set1(1'b0, '0);
      checks++;
      if (s1_occ !== 2'd0 || s1_ov !== 1'b0 || s1_oi !== 32'h0) begin
         failures++;
         $display("FAIL flush_discard got=occ%0d v%b %h required=occ0 v0 0",
                  s1_occ, s1_ov, s1_oi);
      end
      tick();
      checks++;
      if (s1_ov !== 1'b0 || s1_st !== 16'(exp_stall)) begin
         failures++;
         $display("FAIL flush_after got=v%b st%0d required=v0 st%0d",
                  s1_ov, s1_st, exp_stall);
      end
   endtask

   task automatic test_skid0();
      s0_or = 1'b0;
      set0(1'b1, 32'h2404_0C00);
      tick();
      checks++;
      if (s0_ov !== 1'b1 || s0_occ !== 2'd1 || s0_oi !== 32'h2404_0C00) begin
         failures++;
         $display("FAIL s0_load got=v%b occ%0d %h required=v1 occ1 24040c00",
                  s0_ov, s0_occ, s0_oi);
      end
      set0(1'b1, 32'h2404_0C01);
      #1;
      checks++;
      if (s0_ir !== 1'b0) begin
         failures++;
         $display("FAIL s0_ready_low got=%b required=0", s0_ir);
      end
      s0_or = 1'b1;
      #1;
      checks++;
      if (s0_ir !== 1'b1) begin
         failures++;
         $display("FAIL s0_ready_comb got=%b required=1", s0_ir);
      end
      for (int k = 1; k <= 4; k++) begin
         set0(1'b1, 32'h2404_0C00 + k);
         tick();
         checks++;
         if (s0_ov !== 1'b1 || s0_occ !== 2'd1 ||
             s0_oi !== 32'h2404_0C00 + k) begin
            failures++;
            $display("FAIL s0_replace_%0d got=v%b occ%0d %h required=v1 occ1 %h",
                     k, s0_ov, s0_occ, s0_oi, 32'h2404_0C00 + k);
         end
      end
      set0(1'b0, '0);
      tick();
      checks++;
      if (s0_ov !== 1'b0 || s0_occ !== 2'd0 || s0_oi !== 32'h0) begin
         failures++;
         $display("FAIL s0_drain got=v%b occ%0d %h required=v0 occ0 0",
                  s0_ov, s0_occ, s0_oi);
      end
   endtask

   task automatic test_reset_midstream();
      s1_or = 1'b0;
      set1(1'b1, 32'h2405_0000);
      tick();
      set1(1'b1, 32'h2405_0001);
      tick();
      set1(1'b1, 32'h2405_0002);
      #2;
      reset = 1'b0;
      #1;
      exp_stall = 0;
      checks++;
      if (s1_occ !== 2'd0 || s1_ov !== 1'b0 || s1_ir !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_ctl got=occ%0d v%b r%b required=occ0 v0 r1",
                  s1_occ, s1_ov, s1_ir);
      end
      checks++;
      if (s1_oi !== 32'h0 || s1_st !== 16'h0) begin
         failures++;
         $display("FAIL rst_mid_data got=%h st%0d required=0 st0",
                  s1_oi, s1_st);
      end
      tick();
      set1(1'b0, '0);
      reset = 1'b1;
      tick();
      checks++;
      if (s1_occ !== 2'd0 || s1_ov !== 1'b0) begin
         failures++;
         $display("FAIL rst_release got=occ%0d v%b required=occ0 v0",
                  s1_occ, s1_ov);
      end
   endtask

   task automatic test_saturation();
      s1_or = 1'b0;
      set1(1'b1, 32'h2406_0000);
      tick();
      set1(1'b1, 32'h2406_0001);
      tick();
      set1(1'b1, 32'h2406_0002);
      repeat (65534) tick();
      checks++;
      if (s1_st !== 16'hFFFE) begin
         failures++;
         $display("FAIL sat_pre got=%h required=fffe", s1_st);
      end
      tick();
      checks++;
      if (s1_st !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_hit got=%h required=ffff", s1_st);
      end
      repeat (5) tick();
      checks++;
      if (s1_st !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_hold got=%h required=ffff", s1_st);
      end
      set1(1'b0, '0);
      s1_or = 1'b1;
      repeat (3) tick();
      checks++;
      if (s1_occ !== 2'd0 || s1_st !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_drain got=occ%0d %h required=occ0 ffff",
                  s1_occ, s1_st);
      end
   endtask

   initial begin
      reset    = 1'b0;
      s1_flush = 1'b0;
      s1_or    = 1'b0;
      s0_flush = 1'b0;
      s0_or    = 1'b0;
      set1(1'b0, '0);
      set0(1'b0, '0);
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_skid0();
      test_reset_midstream();
      test_saturation();
      tick();
      checks++;
      if (q1.size() != 0 || q0.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d/%0d required=0/0",
                  q1.size(), q0.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
